// File: rtl/core_pkg.sv
// core_pkg: shared definitions for the 5-stage RISC-V core front end.
//   XLEN          datapath / PC width
//   RESET_PC      default first fetch address after reset
//   NOP_INSTR     bubble instruction (addi x0,x0,0)
//   fetch_state_e instruction-fetch FSM states (2-bit encoding)
//   pc_plus4      PC increment, modulo 2^XLEN
package core_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // REQ : request presented to imem
    // WAIT: request accepted, waiting for its response
    // HOLD: response captured while decode stalls
    // DROP: response of a redirected-away request still outstanding
    typedef enum logic [1:0] {
        REQ  = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10,
        DROP = 2'b11
    } fetch_state_e;

    // Natural truncation gives the 0xFFFF_FFFC -> 0 wrap-around.
    function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// if_id_reg: IF/ID pipeline register.
//   Priority: flush > stall > load > hold.
//   flush   : valid_d=0, instr_d=NOP_INSTR; pc_d / pc_plus4_d keep their value.
//   stall   : everything holds.
//   load    : capture {instr_in, pc_in, pc_plus4_in}, valid_d=1.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   load, stall, flush               control (see priority above)
//   instr_in, pc_in, pc_plus4_in     data to capture on load
//   instr_d, pc_d, pc_plus4_d, valid_d  register outputs to decode
module if_id_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            stall,
    input  logic            flush,
    input  logic [31:0]     instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pc_plus4_in,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order across processes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
            valid_d    <= 1'b0;
        end else if (flush) begin
            instr_d <= NOP_INSTR;
            valid_d <= 1'b0;
        end else if (!stall && load) begin
            instr_d    <= instr_in;
            pc_d       <= pc_in;
            pc_plus4_d <= pc_plus4_in;
            valid_d    <= 1'b1;
        end
    end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage plus IF/ID register.
//   Owns pc_f, keeps one request outstanding to imem (valid/ready), buffers a
//   response that arrives during a decode stall, and handles flush and
//   execute-stage redirect (pcsrc_e, highest priority in every state).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   imem_req_valid/addr/ready          fetch request handshake (addr = pc_f)
//   imem_rsp_valid/data                one response pulse per accepted request
//   stall_d, flush_d                   hazard-unit controls for IF/ID
//   pcsrc_e, pc_target_e               taken branch/jump redirect
//   instr_d, pc_d, pc_plus4_d, valid_d IF/ID outputs to decode
// Optional: define IF_STAGE_MISALIGN_CHK_EN to add fetch_misalign_o, a flag
//   registered with IF/ID that marks entries whose pc_d[1:0] != 0.
module if_stage #(
    parameter int               XLEN      = core_pkg::XLEN,
    parameter logic [XLEN-1:0]  RESET_PC  = XLEN'(core_pkg::RESET_PC),
    parameter logic [31:0]      NOP_INSTR = core_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pcsrc_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
`ifdef IF_STAGE_MISALIGN_CHK_EN
    ,
    output logic            fetch_misalign_o
`endif
);

    import core_pkg::*;

    fetch_state_e    state, state_n;
    logic [XLEN-1:0] pc_f, pc_f_n;
    logic [XLEN-1:0] req_pc, req_pc_n;
    logic [31:0]     hold_buf, hold_buf_n;
    logic            started;     // keeps req_valid low until the first edge after reset
    logic            fire;
    logic            load;
    logic [31:0]     load_instr;

    assign imem_req_valid = started && (state == REQ);
    assign imem_req_addr  = pc_f;
    assign fire           = imem_req_valid && imem_req_ready;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        pc_f_n     = pc_f;
        req_pc_n   = req_pc;
        hold_buf_n = hold_buf;
        load       = 1'b0;
        load_instr = imem_rsp_data;

        unique case (state)
            REQ: begin
                if (pcsrc_e) begin
                    pc_f_n = pc_target_e;
                    // An already-issued request still owes a response.
                    if (fire) state_n = DROP;
                end else if (fire) begin
                    req_pc_n = pc_f;
                    state_n  = WAIT;
                end
            end
            WAIT: begin
                if (pcsrc_e) begin
                    pc_f_n  = pc_target_e;
                    state_n = imem_rsp_valid ? REQ : DROP;
                end else if (imem_rsp_valid) begin
                    if (!stall_d) begin
                        load    = 1'b1;
                        pc_f_n  = pc_plus4(req_pc);
                        state_n = REQ;
                    end else begin
                        hold_buf_n = imem_rsp_data;
                        state_n    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (pcsrc_e) begin
                    pc_f_n  = pc_target_e;
                    state_n = REQ;
                end else if (!stall_d) begin
                    load       = 1'b1;
                    load_instr = hold_buf;
                    pc_f_n     = pc_plus4(req_pc);
                    state_n    = REQ;
                end
            end
            DROP: begin
                if (pcsrc_e) pc_f_n = pc_target_e;
                if (imem_rsp_valid) state_n = REQ;
            end
            default: state_n = REQ;
        endcase
    end

    // NOTE: the hold buffer is reset along with the control state; it is a
    // single word, so clearing it costs nothing and keeps X out of IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= REQ;
            pc_f     <= RESET_PC;
            req_pc   <= '0;
            hold_buf <= '0;
            started  <= 1'b0;
        end else begin
            state    <= state_n;
            pc_f     <= pc_f_n;
            req_pc   <= req_pc_n;
            hold_buf <= hold_buf_n;
            started  <= 1'b1;
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .stall       (stall_d),
        .flush       (flush_d || pcsrc_e),
        .instr_in    (load_instr),
        .pc_in       (req_pc),
        .pc_plus4_in (pc_plus4(req_pc)),
        .instr_d     (instr_d),
        .pc_d        (pc_d),
        .pc_plus4_d  (pc_plus4_d),
        .valid_d     (valid_d)
    );

`ifdef IF_STAGE_MISALIGN_CHK_EN
    // Same priority as the IF/ID register it accompanies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_misalign_o <= 1'b0;
        end else if (flush_d || pcsrc_e) begin
            fetch_misalign_o <= 1'b0;
        end else if (!stall_d && load) begin
            fetch_misalign_o <= |req_pc[1:0];
        end
    end
`endif

    // A response is only legal while one is owed.
    rsp_only_when_owed: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (state == WAIT || state == DROP)
    );

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed, table-driven bench for if_stage.
// Each vector is one clock cycle: inputs applied after the falling edge,
// registered outputs compared 1 time unit after the following rising edge.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        stall_d;
    logic        flush_d;
    logic        pcsrc_e;
    logic [31:0] pc_target_e;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
`ifdef IF_STAGE_MISALIGN_CHK_EN
    logic        fetch_misalign_o;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    if_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .stall_d        (stall_d),
        .flush_d        (flush_d),
        .pcsrc_e        (pcsrc_e),
        .pc_target_e    (pc_target_e),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .pc_plus4_d     (pc_plus4_d),
        .valid_d        (valid_d)
`ifdef IF_STAGE_MISALIGN_CHK_EN
        ,
        .fetch_misalign_o (fetch_misalign_o)
`endif
    );

    typedef struct {
        logic        rdy, rv;
        logic [31:0] rd;
        logic        st, fl, br;
        logic [31:0] tgt;
        logic        e_rv;
        logic [31:0] e_ra;
        logic        e_vd;
        logic [31:0] e_in, e_pc, e_p4;
    } vec_t;

    vec_t vq[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic fl, input logic br, input logic [31:0] tgt,
                       input logic e_rv, input logic [31:0] e_ra, input logic e_vd,
                       input logic [31:0] e_in, input logic [31:0] e_pc, input logic [31:0] e_p4);
        vec_t v;
        v.rdy = rdy; v.rv = rv; v.rd = rd; v.st = st; v.fl = fl; v.br = br; v.tgt = tgt;
        v.e_rv = e_rv; v.e_ra = e_ra; v.e_vd = e_vd; v.e_in = e_in; v.e_pc = e_pc; v.e_p4 = e_p4;
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        imem_req_ready = v.rdy;
        imem_rsp_valid = v.rv;
        imem_rsp_data  = v.rd;
        stall_d        = v.st;
        flush_d        = v.fl;
        pcsrc_e        = v.br;
        pc_target_e    = v.tgt;
    endtask

    task automatic idle();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        stall_d        = 1'b0;
        flush_d        = 1'b0;
        pcsrc_e        = 1'b0;
        pc_target_e    = '0;
    endtask

    task automatic check_outputs(input string tag, input vec_t v);
        check({tag, "_req_valid"}, 32'(imem_req_valid), 32'(v.e_rv));
        check({tag, "_req_addr"},  imem_req_addr,       v.e_ra);
        check({tag, "_valid_d"},   32'(valid_d),        32'(v.e_vd));
        check({tag, "_instr_d"},   instr_d,             v.e_in);
        if (v.e_vd) begin
            check({tag, "_pc_d"},       pc_d,       v.e_pc);
            check({tag, "_pc_plus4_d"}, pc_plus4_d, v.e_p4);
        end
    endtask

    // One clock cycle: apply after falling edge, compare after rising edge.
    task automatic step(input string tag, input vec_t v);
        @(negedge clk);
        drive(v);
        @(posedge clk);
        #1;
        check_outputs(tag, v);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req_valid"},  32'(imem_req_valid), 32'd0);
        check({tag, "_valid_d"},    32'(valid_d),        32'd0);
        check({tag, "_instr_d"},    instr_d,             NOP);
        check({tag, "_pc_d"},       pc_d,                32'd0);
        check({tag, "_pc_plus4_d"}, pc_plus4_d,          32'd0);
    endtask

    initial begin
        vec_t v;
        //  rdy rv rd            st fl br tgt            e_rv e_ra          e_vd e_in          e_pc          e_p4
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,        32'h0);  // started
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,        32'h0);  // accept 0x0
        add(0, 1, 32'h00500093, 0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);  // N+2 load
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);  // accept 0x4
        add(0, 1, 32'h00a00113, 1, 0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);  // rsp under stall
        add(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
        add(0, 0, 32'h0,        1, 0, 0, 32'h0,        0, 32'h4,        1, 32'h00500093, 32'h0,        32'h4);
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h8,        1, 32'h00a00113, 32'h4,        32'h8);  // held word out
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h8,        1, 32'h00a00113, 32'h4,        32'h8);  // accept 0x8
        add(0, 0, 32'h0,        0, 0, 1, 32'h100,      0, 32'h100,      0, NOP,          32'h4,        32'h8);  // redirect in WAIT
        add(0, 1, 32'hdeadbeef, 0, 0, 0, 32'h0,        1, 32'h100,      0, NOP,          32'h4,        32'h8);  // dropped
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h4,        32'h8);
        add(0, 1, 32'h00108093, 0, 0, 0, 32'h0,        1, 32'h104,      1, 32'h00108093, 32'h100,      32'h104);
        add(0, 0, 32'h0,        1, 1, 0, 32'h0,        1, 32'h104,      0, NOP,          32'h100,      32'h104);  // flush+stall
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h104,      0, NOP,          32'h100,      32'h104);  // ready low
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h104,      0, NOP,          32'h100,      32'h104);
        add(0, 0, 32'h0,        0, 0, 1, 32'h40,       1, 32'h40,       0, NOP,          32'h100,      32'h104);  // redirect in REQ
        add(0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h40,       0, NOP,          32'h100,      32'h104);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h40,       0, NOP,          32'h100,      32'h104);  // accept 0x40
        add(0, 1, 32'h00000513, 0, 0, 0, 32'h0,        1, 32'h44,       1, 32'h00000513, 32'h40,       32'h44);
        add(1, 0, 32'h0,        0, 0, 1, 32'h200,      0, 32'h200,      0, NOP,          32'h40,       32'h44);  // redirect + fire
        add(0, 1, 32'h11111111, 0, 0, 0, 32'h0,        1, 32'h200,      0, NOP,          32'h40,       32'h44);  // dropped
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h200,      0, NOP,          32'h40,       32'h44);
        add(0, 1, 32'h22222222, 0, 0, 1, 32'h300,      1, 32'h300,      0, NOP,          32'h40,       32'h44);  // redirect + rsp
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h300,      0, NOP,          32'h40,       32'h44);
        add(0, 1, 32'h33333333, 1, 0, 0, 32'h0,        0, 32'h300,      0, NOP,          32'h40,       32'h44);  // into HOLD
        add(0, 0, 32'h0,        1, 0, 1, 32'hfffffffc, 1, 32'hfffffffc, 0, NOP,          32'h40,       32'h44);  // redirect in HOLD
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'hfffffffc, 0, NOP,          32'h40,       32'h44);
        add(0, 1, 32'h44444444, 0, 0, 0, 32'h0,        1, 32'h0,        1, 32'h44444444, 32'hfffffffc, 32'h0);  // wrap
        add(1, 0, 32'h0,        0, 1, 0, 32'h0,        0, 32'h0,        0, NOP,          32'hfffffffc, 32'h0);  // flush, fetch goes on
        add(0, 1, 32'h55555555, 0, 0, 0, 32'h0,        1, 32'h4,        1, 32'h55555555, 32'h0,        32'h4);
        add(1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h4,        1, 32'h55555555, 32'h0,        32'h4);
        add(0, 1, 32'h66666666, 0, 1, 0, 32'h0,        1, 32'h8,        0, NOP,          32'h0,        32'h4);  // flush beats load

        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        foreach (vq[i]) step($sformatf("v%0d", i), vq[i]);

        // Reset pulsed mid-WAIT: outputs return without waiting for an edge.
        v = '{rdy: 1, rv: 0, rd: 0, st: 0, fl: 0, br: 0, tgt: 0,
              e_rv: 0, e_ra: 32'h8, e_vd: 0, e_in: NOP, e_pc: 0, e_p4: 0};
        step("pre_rst", v);
        idle();
        rst_n = 1'b0;
        #2;
        check_reset_values("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after release: request not yet visible, so no accept.
        v = '{rdy: 1, rv: 0, rd: 0, st: 0, fl: 0, br: 0, tgt: 0,
              e_rv: 1, e_ra: 32'h0, e_vd: 0, e_in: NOP, e_pc: 0, e_p4: 0};
        step("post_rst0", v);
        v.e_rv = 0;
        step("post_rst1", v);
        v = '{rdy: 0, rv: 1, rd: 32'h77777777, st: 0, fl: 0, br: 0, tgt: 0,
              e_rv: 1, e_ra: 32'h4, e_vd: 1, e_in: 32'h77777777, e_pc: 32'h0, e_p4: 32'h4};
        step("post_rst2", v);

        @(negedge clk);
        idle();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the 5-stage RISC-V core.
- Owns the fetch PC and issues one outstanding request at a time to instruction memory over a valid/ready handshake.
- Buffers the returned word and presents Instr/PC/PC+4 to the decode stage, where the control unit consumes Op/funct3/funct7.
- Handles decode stall, decode flush and execute-stage branch/jump redirect.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on instr_d when invalid.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_addr  out  XLEN  fetch address (= pc_f).
- imem_req_ready  in  1  memory accepts request.
- imem_rsp_valid  in  1  read data valid (one pulse per accepted request).
- imem_rsp_data  in  32  instruction word.
- stall_d  in  1  hold IF/ID contents (hazard unit).
- flush_d  in  1  bubble IF/ID (hazard unit).
- pcsrc_e  in  1  taken branch/jump in EX.
- pc_target_e  in  XLEN  redirect target.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  XLEN  IF/ID PC.
- pc_plus4_d  out  XLEN  IF/ID PC+4.
- valid_d  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (async, rst_n=0):
  - pc_f=RESET_PC, state=REQ.
  - valid_d=0, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0, hold buffer cleared.
  - imem_req_valid is 0 during reset, 1 from the first edge after release.
  - Imem is reset on the same rst_n, so no stale response survives reset.
- FSM states: REQ, WAIT, HOLD, DROP.
  - imem_req_valid=1 only in REQ; imem_req_addr=pc_f.
  - The address may change while valid && !ready, because the imem contract allows it.
  - REQ: on valid&&ready, latch req_pc=pc_f and go to WAIT.
  - WAIT, on rsp_valid:
    - If !stall_d: load IF/ID with {rsp_data, req_pc, req_pc+4, valid=1}, set pc_f=req_pc+4, go to REQ.
    - If stall_d: capture the word into the 1-entry hold buffer, go to HOLD.
  - HOLD: when stall_d=0, load IF/ID from the buffer, set pc_f=req_pc+4, go to REQ.
- Minimum latency: request accepted in cycle N, response in N+1, IF/ID valid at N+2. Throughput is 1 instruction per 2 cycles minimum (single outstanding request).
- IF/ID register:
  - When no new word is loaded, IF/ID holds its value.
  - stall_d holds it unconditionally.
  - flush_d sets valid_d=0 and instr_d=NOP_INSTR next edge; pc_d and pc_plus4_d are don't-care and hold.
  - flush_d overrides stall_d and any same-cycle load.
  - flush_d does not disturb the in-flight fetch.
- Redirect (pcsrc_e=1) has the highest priority and acts in every state:
  - pc_f<=pc_target_e; IF/ID is invalidated as for a flush.
  - REQ with handshake firing the same cycle: the old request is already issued, go to DROP.
  - REQ without handshake: stay in REQ with the new address.
  - WAIT with rsp_valid the same cycle: discard the response, go to REQ.
  - WAIT without rsp_valid: go to DROP.
  - HOLD: discard the buffer, go to REQ.
  - DROP: only update pc_f.
- DROP: wait for rsp_valid, discard the data, go to REQ. No IF/ID update.
- Arithmetic: PC+4 is modulo 2^XLEN; wrap-around at 0xFFFF_FFFC gives 0.
- rsp_valid outside WAIT/DROP is a protocol error: ignored. Covered by an assertion only.

Optional Feature:
- Macro IF_STAGE_MISALIGN_CHK_EN.
- When defined:
  - Adds output fetch_misalign_o (1 bit). It is registered alongside IF/ID: 1 when the loaded pc_d[1:0]!=0, cleared on flush and reset.
  - Any pcsrc_e with pc_target_e[1:0]!=0 still redirects, but the resulting request is issued and its IF/ID entry carries the flag.
- When undefined: no port, no logic; low PC bits are passed through unchecked.

Decomposition:
- Shared package (core_pkg): XLEN, RESET_PC default, NOP_INSTR, and the fetch FSM state enum (REQ/WAIT/HOLD/DROP, 2-bit encoding).
- Natural sub-module: if_id_reg, the IF/ID pipeline register with load/stall/flush priority. The FSM, PC and hold buffer stay in the top.

Test Plan:
- Reset release, ready=1, 1-cycle rsp returning 0x00500093 → req addr 0x0, 0x4, 0x8…; at N+2 instr_d=0x00500093, pc_d=0, pc_plus4_d=4, valid_d=1.
- rsp arrives with stall_d high for 3 cycles → IF/ID unchanged and imem_req_valid=0 for 3 cycles; next edge after stall drops, the held word appears with the correct pc_d.
- pcsrc_e=1, target 0x100, while in WAIT and no rsp → next response discarded (valid_d stays 0); next request address is 0x100.
- flush_d and stall_d asserted together with a valid IF/ID → valid_d=0, instr_d=0x00000013.
- imem_req_ready low for 4 cycles, then redirect to 0x40 during the wait → the accepted address is 0x40, never the stale PC.
- rst_n pulsed low mid-WAIT → outputs return to reset values asynchronously; first post-reset request is to RESET_PC.
